arb_puf_ctrl: RTL and testbench



---
 rtl/arb_puf_pkg.sv | 17 +
 rtl/arb_puf_sync2.sv | 22 ++
 rtl/arb_puf_ctrl.sv | 138 +++++++++++++
 tb/tb_arb_puf_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arb_puf_pkg.sv
// Shared types and default parameters for the arbiter-PUF sequencer.
package arb_puf_pkg;

  localparam int CHAL_W_DEF     = 64;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int EVAL_CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } arb_puf_state_t;

endpackage

// File: rtl/arb_puf_sync2.sv
// Two-flop synchronizer bringing the raw arbiter output into the ACLK domain.
module arb_puf_sync2 (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic d,
  output logic q
);

  logic meta_r;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/arb_puf_ctrl.sv
// Arbiter-PUF sequencer: repeats clear/launch/settle/sample N times and
// reports a majority-voted response bit together with the ones count.
module arb_puf_ctrl
  import arb_puf_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int EVAL_CNT_W = EVAL_CNT_W_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CHAL_W-1:0]     challenge_i,
  input  logic [EVAL_CNT_W-1:0] n_evals_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  response_o,
  output logic [EVAL_CNT_W-1:0] ones_cnt_o,
  output logic                  tie_o,
  output logic [CHAL_W-1:0]     puf_chal_o,
  output logic                  puf_rst_o,
  output logic                  puf_launch_o,
  input  logic                  puf_resp_i
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  arb_puf_state_t        state_r;
  logic [EVAL_CNT_W-1:0] n_r;
  logic [EVAL_CNT_W-1:0] eval_r;
  logic [EVAL_CNT_W-1:0] ones_r;
  logic [SET_W-1:0]      settle_r;

  logic                  resp_sync_s;
  logic [EVAL_CNT_W-1:0] ones_nx_s;
  logic [EVAL_CNT_W-1:0] eval_nx_s;
  logic [EVAL_CNT_W:0]   twice_ones_s;
  logic [EVAL_CNT_W:0]   n_ext_s;

  arb_puf_sync2 u_sync2 (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .d       (puf_resp_i),
    .q       (resp_sync_s)
  );

  // Counter updates and the vote operands; the doubling is one bit wider so it never wraps.
  always_comb begin
    ones_nx_s    = ones_r + EVAL_CNT_W'(resp_sync_s);
    eval_nx_s    = eval_r + EVAL_CNT_W'(1'b1);
    twice_ones_s = {ones_nx_s, 1'b0};
    n_ext_s      = {1'b0, n_r};
  end

  // Sequencer: pulse outputs are registered alongside the transition into their state.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r      <= ST_IDLE;
      n_r          <= '0;
      eval_r       <= '0;
      ones_r       <= '0;
      settle_r     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      response_o   <= 1'b0;
      ones_cnt_o   <= '0;
      tie_o        <= 1'b0;
      puf_chal_o   <= '0;
      puf_rst_o    <= 1'b0;
      puf_launch_o <= 1'b0;
    end else if (abort_i && (state_r != ST_IDLE)) begin
      // Results from the last completed run are left untouched.
      state_r      <= ST_IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      puf_rst_o    <= 1'b0;
      puf_launch_o <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      puf_rst_o    <= 1'b0;
      puf_launch_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            puf_chal_o <= challenge_i;
            n_r        <= (n_evals_i == '0) ? EVAL_CNT_W'(1'b1) : n_evals_i;
            eval_r     <= '0;
            ones_r     <= '0;
            busy_o     <= 1'b1;
            puf_rst_o  <= 1'b1;
            state_r    <= ST_CLEAR;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          puf_launch_o <= 1'b1;
          state_r      <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          settle_r <= SET_W'(SETTLE_CYC - 1);
          state_r  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_r == '0) begin
            state_r  <= ST_SAMPLE;
          end else begin
            settle_r <= settle_r - SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          ones_r <= ones_nx_s;
          eval_r <= eval_nx_s;
          if (eval_nx_s == n_r) begin
            done_o     <= 1'b1;
            ones_cnt_o <= ones_nx_s;
            response_o <= (twice_ones_s > n_ext_s);
            tie_o      <= (twice_ones_s == n_ext_s);
            state_r    <= ST_DONE;
          end else begin
            puf_rst_o  <= 1'b1;
            state_r    <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_puf_ctrl.sv
// Randomized self-checking bench for arb_puf_ctrl against a run-level timing/vote model.
module tb_arb_puf_ctrl;

  localparam int CHAL_W     = 64;
  localparam int SETTLE_CYC = 8;
  localparam int EVAL_CNT_W = 8;
  localparam int PER        = SETTLE_CYC + 3;

  logic                  ACLK = 1'b0;
  logic                  ARESETN;
  logic                  start_i;
  logic                  abort_i;
  logic [CHAL_W-1:0]     challenge_i;
  logic [EVAL_CNT_W-1:0] n_evals_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  response_o;
  logic [EVAL_CNT_W-1:0] ones_cnt_o;
  logic                  tie_o;
  logic [CHAL_W-1:0]     puf_chal_o;
  logic                  puf_rst_o;
  logic                  puf_launch_o;
  logic                  puf_resp_i;

  int n_checks = 0;
  int n_errs   = 0;

  // Results of the last completed run, as the model sees them.
  int exp_ones = 0;
  bit exp_resp = 1'b0;
  bit exp_tie  = 1'b0;

  arb_puf_ctrl #(
    .CHAL_W     (CHAL_W),
    .SETTLE_CYC (SETTLE_CYC),
    .EVAL_CNT_W (EVAL_CNT_W)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .challenge_i  (challenge_i),
    .n_evals_i    (n_evals_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .response_o   (response_o),
    .ones_cnt_o   (ones_cnt_o),
    .tie_o        (tie_o),
    .puf_chal_o   (puf_chal_o),
    .puf_rst_o    (puf_rst_o),
    .puf_launch_o (puf_launch_o),
    .puf_resp_i   (puf_resp_i)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One run. Cycle k is the cycle after the k-th posedge counted from the edge that samples start.
  // Responses: bit j of pat for evaluation j, or random when rnd is set.
  task automatic do_run(input string name, input int n_evals, input logic [63:0] chal,
                        input logic [31:0] pat, input bit rnd,
                        input int restart_at, input int abort_at, input int reset_at);
    int n_eff, ones, exp_done, cyc, n_launch, n_rst, n_done, done_cyc, chal_bad;
    bit stop, b, full;
    n_eff    = (n_evals == 0) ? 1 : n_evals;
    exp_done = n_eff * PER + 1;
    full     = (abort_at < 0) && (reset_at < 0);
    ones = 0; n_launch = 0; n_rst = 0; n_done = 0; done_cyc = -1; chal_bad = 0; stop = 1'b0;

    @(negedge ACLK);
    start_i     = 1'b1;
    challenge_i = chal;
    n_evals_i   = EVAL_CNT_W'(n_evals);
    @(negedge ACLK);
    start_i     = 1'b0;
    challenge_i = {$urandom, $urandom};
    n_evals_i   = EVAL_CNT_W'($urandom);
    cyc = 1;
    while (!stop && cyc <= exp_done + 3) begin
      if (cyc == 1) chk({name, ":busy_rise"}, busy_o, 1'b1);
      if (puf_rst_o) begin
        chk({name, ":rst_cycle"}, cyc, 1 + PER * n_rst);
        n_rst++;
      end
      if (puf_launch_o) begin
        chk({name, ":launch_cycle"}, cyc, 2 + PER * n_launch);
        b = (rnd || n_launch > 31) ? 1'($urandom) : pat[n_launch];
        puf_resp_i = b;
        if (n_launch < n_eff) ones += int'(b);
        n_launch++;
      end
      if (busy_o && puf_chal_o !== chal) chal_bad++;
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
        if (full) begin
          chk({name, ":ones"}, ones_cnt_o, ones);
          chk({name, ":response"}, response_o, (2 * ones > n_eff));
          chk({name, ":tie"}, tie_o, (2 * ones == n_eff));
          chk({name, ":chal_at_done"}, puf_chal_o, chal);
        end
      end
      if (full && cyc == exp_done + 1) chk({name, ":busy_fall"}, busy_o, 1'b0);
      if (cyc == restart_at + 1) chk({name, ":chal_kept"}, puf_chal_o, chal);
      if (cyc == abort_at + 1) begin
        abort_i = 1'b0;
        chk({name, ":abort_idle"}, {busy_o, puf_rst_o, puf_launch_o, done_o}, 4'b0000);
      end
      if (cyc == reset_at + 1) begin
        chk({name, ":reset_clear"},
            {busy_o, done_o, response_o, ones_cnt_o, tie_o, puf_rst_o, puf_launch_o}, 0);
        chk({name, ":reset_chal"}, puf_chal_o, 0);
        ARESETN = 1'b1;
        stop = 1'b1;
      end
      // Drive for the next edge.
      if (cyc == restart_at) begin
        start_i = 1'b1;
        challenge_i = ~chal;
        n_evals_i = EVAL_CNT_W'(n_evals + 1);
      end else begin
        start_i = 1'b0;
      end
      if (cyc == abort_at) abort_i = 1'b1;
      if (cyc == reset_at) ARESETN = 1'b0;
      @(negedge ACLK);
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;

    if (full) begin
      exp_ones = ones;
      exp_resp = (2 * ones > n_eff);
      exp_tie  = (2 * ones == n_eff);
      chk({name, ":done_cycle"}, done_cyc, exp_done);
      chk({name, ":done_count"}, n_done, 1);
      chk({name, ":launch_count"}, n_launch, n_eff);
      chk({name, ":rst_count"}, n_rst, n_eff);
      chk({name, ":chal_stable"}, chal_bad, 0);
      chk({name, ":chal_held"}, puf_chal_o, chal);
    end else if (abort_at >= 0) begin
      chk({name, ":no_done"}, n_done, 0);
      chk({name, ":busy_after_abort"}, busy_o, 1'b0);
      chk({name, ":kept_results"}, {ones_cnt_o, response_o, tie_o},
          {EVAL_CNT_W'(exp_ones), exp_resp, exp_tie});
      chk({name, ":chal_stable"}, chal_bad, 0);
    end else begin
      exp_ones = 0;
      exp_resp = 1'b0;
      exp_tie  = 1'b0;
      chk({name, ":no_done"}, n_done, 0);
    end
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    ARESETN     = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    challenge_i = {$urandom, $urandom};
    n_evals_i   = EVAL_CNT_W'($urandom);
    puf_resp_i  = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", {busy_o, done_o, response_o, ones_cnt_o, tie_o, puf_rst_o, puf_launch_o}, 0);
    chk("reset_chal", puf_chal_o, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    do_run("single",   1, 64'hDEADBEEF_01234567, 32'h1, 1'b0, -1, -1, -1);
    do_run("majority", 5, {$urandom, $urandom}, 32'b01101, 1'b0, -1, -1, -1);
    do_run("tie",      4, {$urandom, $urandom}, 32'b0011, 1'b0, -1, -1, -1);
    do_run("zero_n",   0, {$urandom, $urandom}, 32'h0, 1'b0, -1, -1, -1);
    do_run("abort",    2, {$urandom, $urandom}, 32'h0, 1'b1, 5, 6, -1);
    do_run("reset",    3, {$urandom, $urandom}, 32'h0, 1'b1, -1, -1, 2 * PER);
    do_run("after_reset", 3, {$urandom, $urandom}, 32'h0, 1'b1, -1, -1, -1);
    do_run("max_n",  255, {$urandom, $urandom}, 32'h0, 1'b1, -1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      do_run("random", $urandom_range(1, 12), {$urandom, $urandom}, 32'h0, 1'b1, -1, -1, -1);
    end
    for (int i = 0; i < 3; i++) begin
      do_run("rand_abort", $urandom_range(2, 6), {$urandom, $urandom}, 32'h0, 1'b1,
             -1, $urandom_range(1, 2 * PER), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
